// File: rtl/memory_cycle.sv
// MEM stage: byte-addressed data memory with sized loads/stores,
// plus the registered MEM/WB bundle consumed by writeback.
module memory_cycle #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic        MisalignW
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [31:0]   word;
  logic [7:0]    bsel;
  logic [15:0]   hsel;
  logic          mis;
  logic          we;
  logic [3:0]    be;
  logic [31:0]   wdata;

  logic        regwrite_d, regwrite_q;
  logic        resultsrc_d, resultsrc_q;
  logic [4:0]  rd_d, rd_q;
  logic [31:0] pcplus4_d, pcplus4_q;
  logic [31:0] alu_d, alu_q;
  logic [31:0] rdata_d, rdata_q;
  logic        mis_d, mis_q;

  always_comb begin
    idx  = ALU_ResultM[AW+1:2];
    off  = ALU_ResultM[1:0];
    word = mem[idx];
    bsel = word[{off, 3'b000} +: 8];
    hsel = off[1] ? word[31:16] : word[15:0];
    mis  = (MemWriteM || ResultSrcM) &&
           ((funct3M[1:0] == 2'b01 && off[0]) ||
            (funct3M[1:0] == 2'b10 && off != 2'b00));
    we    = MemWriteM && !mis;
    be    = 4'b0000;
    wdata = WriteDataM;
    unique case (1'b1)
      funct3M == 3'b000: begin
        be    = 4'b0001 << off;
        wdata = {4{WriteDataM[7:0]}};
      end
      funct3M == 3'b001: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{WriteDataM[15:0]}};
      end
      funct3M == 3'b010: be = 4'b1111;
      default:           be = 4'b0000;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    unique case (1'b1)
      funct3M == 3'b000: rdata_d = {{24{bsel[7]}}, bsel};
      funct3M == 3'b001: rdata_d = {{16{hsel[15]}}, hsel};
      funct3M == 3'b010: rdata_d = word;
      funct3M == 3'b100: rdata_d = {24'b0, bsel};
      funct3M == 3'b101: rdata_d = {16'b0, hsel};
      default:           rdata_d = '0;
    endcase
    if (mis) rdata_d = '0;
    regwrite_d  = RegWriteM && !mis;
    resultsrc_d = ResultSrcM;
    rd_d        = RD_M;
    pcplus4_d   = PCPlus4M;
    alu_d       = ALU_ResultM;
    mis_d       = mis;
  end

  // reset low at the edge suppresses the store; contents never clear
  always_ff @(posedge clk or negedge rst) begin
    if (rst && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwrite_q  <= 1'b0;
      resultsrc_q <= 1'b0;
      rd_q        <= '0;
      pcplus4_q   <= '0;
      alu_q       <= '0;
      rdata_q     <= '0;
      mis_q       <= 1'b0;
    end else begin
      regwrite_q  <= regwrite_d;
      resultsrc_q <= resultsrc_d;
      rd_q        <= rd_d;
      pcplus4_q   <= pcplus4_d;
      alu_q       <= alu_d;
      rdata_q     <= rdata_d;
      mis_q       <= mis_d;
    end
  end

  assign RegWriteW   = regwrite_q;
  assign ResultSrcW  = resultsrc_q;
  assign RD_W        = rd_q;
  assign PCPlus4W    = pcplus4_q;
  assign ALU_ResultW = alu_q;
  assign ReadDataW   = rdata_q;
  assign MisalignW   = mis_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Scoreboard bench for memory_cycle: directed loads/stores,
// expected MEM/WB bundle queued at issue, checked by a monitor.
module tb_memory_cycle;

  localparam int DW = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWriteM = 0, MemWriteM = 0, ResultSrcM = 0;
  logic [4:0]  RD_M = '0;
  logic [2:0]  funct3M = '0;
  logic [31:0] ALU_ResultM = '0, WriteDataM = '0, PCPlus4M = '0;
  logic        RegWriteW, ResultSrcW, MisalignW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

  memory_cycle #(.DEPTH_WORDS(DW)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .RD_M(RD_M), .funct3M(funct3M),
    .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW),
    .ReadDataW(ReadDataW), .MisalignW(MisalignW)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rw;
    logic        rs;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    cmp({nm, ".RegWriteW"}, 32'(RegWriteW), 32'd0);
    cmp({nm, ".ResultSrcW"}, 32'(ResultSrcW), 32'd0);
    cmp({nm, ".RD_W"}, 32'(RD_W), 32'd0);
    cmp({nm, ".PCPlus4W"}, PCPlus4W, 32'd0);
    cmp({nm, ".ALU_ResultW"}, ALU_ResultW, 32'd0);
    cmp({nm, ".ReadDataW"}, ReadDataW, 32'd0);
    cmp({nm, ".MisalignW"}, 32'(MisalignW), 32'd0);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp({e.name, ".RegWriteW"}, 32'(RegWriteW), 32'(e.rw));
      cmp({e.name, ".ResultSrcW"}, 32'(ResultSrcW), 32'(e.rs));
      cmp({e.name, ".RD_W"}, 32'(RD_W), 32'(e.rd));
      cmp({e.name, ".PCPlus4W"}, PCPlus4W, e.pc);
      cmp({e.name, ".ALU_ResultW"}, ALU_ResultW, e.alu);
      cmp({e.name, ".MisalignW"}, 32'(MisalignW), 32'(e.mis));
      if (e.chk_rdata)
        cmp({e.name, ".ReadDataW"}, ReadDataW, e.rdata);
    end
  end

  // drive one instruction on the falling edge; mis/rdata hand-computed
  task automatic issue(input string nm, input logic rw, input logic mw,
                       input logic rs, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] pc,
                       input logic chk, input logic [31:0] erd,
                       input logic emis);
    exp_t e;
    @(negedge clk);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs;
    RD_M = rd; funct3M = f3; ALU_ResultM = addr;
    WriteDataM = wd; PCPlus4M = pc;
    e.name = nm; e.rw = rw & ~emis; e.rs = rs; e.rd = rd;
    e.pc = pc; e.alu = addr; e.rdata = erd;
    e.chk_rdata = chk; e.mis = emis;
    q.push_back(e);
  endtask

  task automatic bubble();
    @(negedge clk);
    RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0;
    RD_M = '0; funct3M = '0; ALU_ResultM = '0;
    WriteDataM = '0; PCPlus4M = '0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() > 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    #2;
    n_chk++;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      RegWriteM = 1'($urandom); MemWriteM = 1'($urandom);
      ResultSrcM = 1'($urandom); RD_M = 5'($urandom);
      funct3M = 3'($urandom); ALU_ResultM = $urandom;
      WriteDataM = $urandom; PCPlus4M = $urandom;
      @(posedge clk);
      #1;
      chk_zero("reset");
    end
    @(negedge clk);
    rst = 1'b1;
    bubble();

    issue("sw_10", 0, 1, 0, 5'd0, 3'b010, 32'h10, 32'hDEADBEEF,
          32'h4, 0, 32'h0, 0);
    issue("lw_10", 1, 0, 1, 5'd7, 3'b010, 32'h10, 32'h0,
          32'h8, 1, 32'hDEADBEEF, 0);
    issue("lb_13", 1, 0, 1, 5'd8, 3'b000, 32'h13, 32'h0,
          32'hC, 1, 32'hFFFFFFDE, 0);
    issue("lbu_13", 1, 0, 1, 5'd9, 3'b100, 32'h13, 32'h0,
          32'h10, 1, 32'h000000DE, 0);
    issue("lh_12", 1, 0, 1, 5'd10, 3'b001, 32'h12, 32'h0,
          32'h14, 1, 32'hFFFFDEAD, 0);
    issue("lhu_10", 1, 0, 1, 5'd11, 3'b101, 32'h10, 32'h0,
          32'h18, 1, 32'h0000BEEF, 0);
    issue("sb_11", 0, 1, 0, 5'd0, 3'b000, 32'h11, 32'hFFFFFF55,
          32'h1C, 0, 32'h0, 0);
    issue("lw_sb", 1, 0, 1, 5'd12, 3'b010, 32'h10, 32'h0,
          32'h20, 1, 32'hDEAD55EF, 0);
    issue("lb_11", 1, 0, 1, 5'd13, 3'b000, 32'h11, 32'h0,
          32'h24, 1, 32'h00000055, 0);
    issue("sw_mis", 0, 1, 0, 5'd0, 3'b010, 32'h12, 32'h01234567,
          32'h28, 0, 32'h0, 1);
    issue("lw_after_mis", 1, 0, 1, 5'd14, 3'b010, 32'h10, 32'h0,
          32'h2C, 1, 32'hDEAD55EF, 0);
    issue("lh_mis", 1, 0, 1, 5'd15, 3'b001, 32'h11, 32'h0,
          32'h30, 1, 32'h0, 1);
    issue("ld_f3_011", 1, 0, 1, 5'd16, 3'b011, 32'h10, 32'h0,
          32'h34, 1, 32'h0, 0);
    issue("alu_a", 1, 0, 0, 5'd17, 3'b000, 32'h104, 32'h0,
          32'h104, 0, 32'h0, 0);
    issue("alu_b", 1, 0, 0, 5'd18, 3'b001, 32'h5, 32'h0,
          32'h108, 0, 32'h0, 0);
    issue("lw_alias", 1, 0, 1, 5'd19, 3'b010, 32'(4*DW) + 32'h10,
          32'h0, 32'h10C, 1, 32'hDEAD55EF, 0);
    issue("sh_16_alias", 0, 1, 0, 5'd0, 3'b001, 32'(4*DW) + 32'h16,
          32'hAAAA1234, 32'h110, 0, 32'h0, 0);
    issue("lw_14", 1, 0, 1, 5'd20, 3'b010, 32'h14, 32'h0,
          32'h114, 0, 32'h0, 0);
    issue("lhu_16", 1, 0, 1, 5'd21, 3'b101, 32'h16, 32'h0,
          32'h118, 1, 32'h00001234, 0);
    bubble();
    drain();

    // store attempted while reset is asserted must be dropped
    @(negedge clk);
    RegWriteM = 1; MemWriteM = 1; ResultSrcM = 0; RD_M = 5'd3;
    funct3M = 3'b010; ALU_ResultM = 32'h10;
    WriteDataM = 32'hAAAAAAAA; PCPlus4M = 32'h200;
    #2;
    rst = 1'b0;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1;
    chk_zero("rst_hold");
    @(negedge clk);
    rst = 1'b1;
    MemWriteM = 0;
    issue("lw_post_rst", 1, 0, 1, 5'd22, 3'b010, 32'h10, 32'h0,
          32'h204, 1, 32'hDEAD55EF, 0);
    bubble();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
